card_dealer: RTL and testbench

//  Draws 10 distinct cards (6-bit codes 0..51) from one 52-card deck using an LFSR with duplicate rejection.

---
 rtl/card_dealer.sv | 175 +++++++++++++++++
 tb/tb_card_dealer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Deals ten distinct cards (0..51) into two 5-card hands using a Galois LFSR with duplicate rejection.
// Optional build macro DEALER_REJECT_CNT_EN adds a saturating reject_cnt output.
module card_dealer #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        deal,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [5:0]  a1,
  output logic [5:0]  a2,
  output logic [5:0]  a3,
  output logic [5:0]  a4,
  output logic [5:0]  a5,
  output logic [5:0]  b1,
  output logic [5:0]  b2,
  output logic [5:0]  b3,
  output logic [5:0]  b4,
  output logic [5:0]  b5
`ifdef DEALER_REJECT_CNT_EN
  ,
  output logic [7:0]  reject_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_s;
  logic [63:0] used_r;
  logic [3:0]  idx_r;
  logic [5:0]  cards_r [10];
  logic        busy_r;
  logic        done_r;
  logic        valid_r;
  logic [5:0]  cand_s;
  logic        accept_s;
  logic        start_s;
  logic        last_s;
  logic        load_ok_s;

  function automatic logic [15:0] galois_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 16'h0000);
  endfunction

  // Next-state, candidate acceptance and LFSR next value
  always_comb begin
    state_s   = state_r;
    cand_s    = lfsr_r[5:0];
    accept_s  = 1'b0;
    start_s   = 1'b0;
    last_s    = 1'b0;
    load_ok_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        load_ok_s = 1'b1;
        start_s   = deal;
        if (deal) begin
          state_s = DRAW;
        end else begin
          state_s = state_r;
        end
      end
      DRAW: begin
        accept_s = (cand_s < 6'd52) && !used_r[cand_s];
        last_s   = accept_s && (idx_r == 4'd9);
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A seed load replaces that cycle's advance, so a simultaneous deal draws from the seed itself
    if (seed_load && load_ok_s) begin
      lfsr_s = (seed == 16'h0000) ? SEED : seed;
    end else begin
      lfsr_s = galois_step(lfsr_r);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // LFSR, used mask, slot index, card slots and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r  <= SEED;
      used_r  <= 64'd0;
      idx_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        cards_r[i] <= 6'd0;
      end
    end else begin
      lfsr_r <= lfsr_s;
      done_r <= 1'b0;
      if (start_s) begin
        used_r  <= 64'd0;
        idx_r   <= 4'd0;
        busy_r  <= 1'b1;
        valid_r <= 1'b0;
      end else if (accept_s) begin
        used_r[cand_s] <= 1'b1;
        idx_r          <= idx_r + 4'd1;
        for (int i = 0; i < 10; i++) begin
          if (idx_r == 4'(i)) begin
            cards_r[i] <= cand_s;
          end
        end
        if (last_s) begin
          busy_r  <= 1'b0;
          valid_r <= 1'b1;
          done_r  <= 1'b1;
        end
      end
    end
  end

`ifdef DEALER_REJECT_CNT_EN
  logic [7:0] reject_cnt_r;

  // Saturating count of rejected candidates in the current or last deal
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_cnt_r <= 8'd0;
    end else if (start_s) begin
      reject_cnt_r <= 8'd0;
    end else if ((state_r == DRAW) && !accept_s && (reject_cnt_r != 8'hFF)) begin
      reject_cnt_r <= reject_cnt_r + 8'd1;
    end
  end

  assign reject_cnt = reject_cnt_r;
`endif

  // Slots alternate between players like a real deal
  assign a1 = cards_r[0];
  assign b1 = cards_r[1];
  assign a2 = cards_r[2];
  assign b2 = cards_r[3];
  assign a3 = cards_r[4];
  assign b3 = cards_r[5];
  assign a4 = cards_r[6];
  assign b4 = cards_r[7];
  assign a5 = cards_r[8];
  assign b5 = cards_r[9];

  assign busy  = busy_r;
  assign done  = done_r;
  assign valid = valid_r;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: a cycle-accurate LFSR deal model feeds a scoreboard queue at deal time.
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        deal;
  logic        busy;
  logic        done;
  logic        valid;
  logic [5:0]  a1, a2, a3, a4, a5, b1, b2, b3, b4, b5;
`ifdef DEALER_REJECT_CNT_EN
  logic [7:0]  reject_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0][5:0] c;
    int              draws;
    int              rej;
  } exp_t;

  exp_t            sb_q[$];
  logic [9:0][5:0] obs;
  int              last_rej;

  assign obs = {b5, a5, b4, a4, b3, a3, b2, a2, b1, a1};

  always #5 clk = ~clk;

  card_dealer dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .deal      (deal),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .a4        (a4),
    .a5        (a5),
    .b1        (b1),
    .b2        (b2),
    .b3        (b3),
    .b4        (b4),
    .b5        (b5)
`ifdef DEALER_REJECT_CNT_EN
    ,
    .reject_cnt(reject_cnt)
`endif
  );

  function automatic logic [15:0] adv(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 16'h0000);
  endfunction

  // Draws from the LFSR value present in the first DRAW cycle
  function automatic exp_t model(input logic [15:0] start);
    exp_t        e;
    logic [63:0] used;
    logic [15:0] l;
    logic [5:0]  cand;
    int          idx;
    used    = 64'd0;
    l       = start;
    idx     = 0;
    e.c     = '0;
    e.draws = 0;
    while (idx < 10 && e.draws < 100000) begin
      cand = l[5:0];
      if (cand < 6'd52 && !used[cand]) begin
        used[cand] = 1'b1;
        e.c[idx]   = cand;
        idx++;
      end
      e.draws++;
      l = adv(l);
    end
    e.rej = (e.draws - 10 > 255) ? 255 : e.draws - 10;
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] x);
    n_assert++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_deal(input logic [15:0] start, input bit push);
    deal = 1'b1;
    if (push) sb_q.push_back(model(start));
    step();
    deal      = 1'b0;
    seed_load = 1'b0;
    check("deal_busy", 16'(busy), 16'd1);
    check("deal_valid", 16'(valid), 16'd0);
  endtask

  task automatic finish_deal(input int intr_at, input string tag);
    int   n;
    bit   seen;
    bit   ok;
    exp_t e;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      deal = (n == intr_at);
      step();
      deal = 1'b0;
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 16'(seen), 16'd1);
    check({tag, "_sb_size"}, 16'(sb_q.size()), 16'd1);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    else e = model(SEED);
    check({tag, "_latency"}, 16'(n), 16'(e.draws));
    check({tag, "_valid"}, 16'(valid), 16'd1);
    check({tag, "_busy"}, 16'(busy), 16'd0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_card%0d", tag, i), 16'(obs[i]), 16'(e.c[i]));
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (obs[i] >= 6'd52) ok = 1'b0;
      for (int j = i + 1; j < 10; j++) begin
        if (obs[i] == obs[j]) ok = 1'b0;
      end
    end
    check({tag, "_distinct"}, 16'(ok), 16'd1);
    last_rej = e.rej;
`ifdef DEALER_REJECT_CNT_EN
    check({tag, "_reject_cnt"}, 16'(reject_cnt), 16'(e.rej));
`endif
    step();
    check({tag, "_done_once"}, 16'(done), 16'd0);
    check({tag, "_valid_hold"}, 16'(valid), 16'd1);
  endtask

  initial begin
    rst       = 1'b1;
    seed_load = 1'b0;
    seed      = 16'h0000;
    deal      = 1'b0;
    last_rej  = 0;

    // reset state
    step();
    step();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    for (int i = 0; i < 10; i++) check($sformatf("rst_card%0d", i), 16'(obs[i]), 16'd0);
    check("rst_lfsr", dut.lfsr_r, SEED);
    rst = 1'b0;

    // seed 1 loaded, deal on the following cycle draws from the advanced value
    seed      = 16'h0001;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    do_deal(adv(16'h0001), 1'b1);
    finish_deal(-1, "s2");

    // zero seed substitutes SEED; same deal as an explicit SEED load
    seed      = 16'h0000;
    seed_load = 1'b1;
    do_deal(SEED, 1'b1);
    finish_deal(-1, "s3");
    seed      = SEED;
    seed_load = 1'b1;
    do_deal(SEED, 1'b1);
    finish_deal(-1, "s3b");

    // deal pulsed three cycles into DRAW is ignored
    seed      = 16'h0000;
    seed_load = 1'b1;
    do_deal(SEED, 1'b1);
    finish_deal(2, "s4");

    // reset mid-deal, then a fresh deal from SEED
    seed      = 16'h0000;
    seed_load = 1'b1;
    do_deal(SEED, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s5_valid", 16'(valid), 16'd0);
    check("s5_busy", 16'(busy), 16'd0);
    check("s5_done", 16'(done), 16'd0);
    for (int i = 0; i < 10; i++) check($sformatf("s5_card%0d", i), 16'(obs[i]), 16'd0);
    check("s5_lfsr", dut.lfsr_r, SEED);
    seed      = 16'h0000;
    seed_load = 1'b1;
    do_deal(SEED, 1'b1);
    finish_deal(-1, "s5");

`ifdef DEALER_REJECT_CNT_EN
    // reject counter holds in DONE and clears on the next deal
    seed      = 16'h0001;
    seed_load = 1'b1;
    do_deal(16'h0001, 1'b1);
    finish_deal(-1, "s6");
    for (int i = 0; i < 3; i++) step();
    check("s6_rej_hold", 16'(reject_cnt), 16'(last_rej));
    seed      = 16'h0000;
    seed_load = 1'b1;
    do_deal(SEED, 1'b1);
    check("s6_rej_clear", 16'(reject_cnt), 16'd0);
    finish_deal(-1, "s6b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
